// File: rtl/sisc_mem_arb.sv
// sisc_mem_arb: arbitrates the single-port SISC main memory between instruction fetch (IF)
// and data access (DM). It runs one transaction at a time through IDLE -> ACCESS -> DONE.
// The memory is driven for MEM_LAT cycles. Read data is captured into the winner's
// registered output, and the winner gets a single-cycle ack in DONE.
// The optional build macro SISC_MEM_ARB_RR_EN turns on round-robin tie-breaking.
// Without it, a tie always goes to DM (fixed priority).

module sisc_mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  // The counter holds MEM_LAT-1 down to 0, so it needs at least one bit even when MEM_LAT is 1.
  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_e          state_q,     state_d;
  gnt_e            gnt_q,       gnt_d;
  gnt_e            last_gnt_q,  last_gnt_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [DW-1:0]   if_rdata_q,  if_rdata_d;
  logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;
  logic            if_ack_q,    if_ack_d;
  logic            dm_ack_q,    dm_ack_d;
  logic            mem_en_q,    mem_en_d;
  logic            mem_we_q,    mem_we_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q,      busy_d;
  logic            dm_win;

  // Tie-break between the requesters. The result is only consulted in IDLE.
  always_comb begin
`ifdef SISC_MEM_ARB_RR_EN
    // On a tie, the grant goes to whichever requester was not served last.
    dm_win = dm_req & (~if_req | (last_gnt_q == GNT_IF));
`else
    dm_win = dm_req;
`endif
  end

  // Next-state and next-output logic. Every memory output is registered from here.
  // The latched mem_addr/mem_wdata/mem_we registers carry the granted transaction,
  // so input changes after the grant are ignored.
  always_comb begin
    // NOTE: every _d gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (if_req || dm_req) begin
          gnt_d       = dm_win ? GNT_DM : GNT_IF;
          last_gnt_d  = dm_win ? GNT_DM : GNT_IF;
          cnt_d       = CNT_INIT;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_win & dm_we;
          mem_addr_d  = dm_win ? dm_addr : if_addr;
          mem_wdata_d = dm_win ? dm_wdata : '0;
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          // Read data is valid in the last access cycle.
          if (!mem_we_q) begin
            if (gnt_q == GNT_DM) dm_rdata_d = mem_rdata;
            else                 if_rdata_d = mem_rdata;
          end
          if_ack_d    = (gnt_q == GNT_IF);
          dm_ack_d    = (gnt_q == GNT_DM);
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        // Encoding 2'd3 is illegal, so recover straight to IDLE with the memory idle.
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs. Reset aborts any transaction in flight without an ack.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_IF;
      last_gnt_q  <= GNT_IF;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge value of its inputs.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sisc_mem_arb.sv
// tb_sisc_mem_arb: directed bench for sisc_mem_arb.
// There are three instances, with MEM_LAT = 1, 2 and 3. They share all inputs, and each
// scenario checks only the instance whose latency it targets.
// Inputs are driven, and outputs sampled, 1 time unit after the rising edge.

module tb_sisc_mem_arb;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] mem_rdata = '0;

  // Index 0: MEM_LAT=1, index 1: MEM_LAT=2, index 2: MEM_LAT=3.
  logic        if_ack_o   [3];
  logic [31:0] if_rdata_o [3];
  logic        dm_ack_o   [3];
  logic [31:0] dm_rdata_o [3];
  logic        mem_en_o   [3];
  logic        mem_we_o   [3];
  logic [15:0] mem_addr_o [3];
  logic [31:0] mem_wdata_o[3];
  logic        busy_o     [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_o[0]), .if_rdata(if_rdata_o[0]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack_o[0]), .dm_rdata(dm_rdata_o[0]),
    .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
    .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata), .busy(busy_o[0])
  );

  sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(2)) u_dut_l2 (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_o[1]), .if_rdata(if_rdata_o[1]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack_o[1]), .dm_rdata(dm_rdata_o[1]),
    .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
    .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata), .busy(busy_o[1])
  );

  sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_o[2]), .if_rdata(if_rdata_o[2]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack_o[2]), .dm_rdata(dm_rdata_o[2]),
    .mem_en(mem_en_o[2]), .mem_we(mem_we_o[2]), .mem_addr(mem_addr_o[2]),
    .mem_wdata(mem_wdata_o[2]), .mem_rdata(mem_rdata), .busy(busy_o[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_f = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_f = 1'b1;
  endtask

  // Step until the MEM_LAT=1 instance acks, bounded by max_cyc cycles.
  task automatic wait_ack(input int max_cyc, output logic got_dm, output logic got_if);
    got_dm = 1'b0;
    got_if = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (if_ack_o[0] || dm_ack_o[0]) begin
        got_dm = dm_ack_o[0];
        got_if = if_ack_o[0];
        return;
      end
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  logic got_dm, got_if;
  logic exp_dm;

  initial begin
    // ---- Reset state ----
    clear_inputs();
    #2 rst_f = 1'b0;
    #2;
    check("rst_mem_en",   mem_en_o[0],   0);
    check("rst_mem_we",   mem_we_o[0],   0);
    check("rst_mem_addr", mem_addr_o[0], 0);
    check("rst_busy",     busy_o[0],     0);
    check("rst_if_rdata", if_rdata_o[0], 0);
    check("rst_dm_rdata", dm_rdata_o[0], 0);
    check("rst_acks",     {if_ack_o[0], dm_ack_o[0]}, 0);
    repeat (2) @(posedge clk);
    #1 rst_f = 1'b1;
    step();
    check("idle_mem_en", mem_en_o[0], 0);

    // ---- 1: IF read, MEM_LAT=1 ----
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 32'h0000_1234;
    step();
    check("t1_mem_en",   mem_en_o[0],   1);
    check("t1_mem_addr", mem_addr_o[0], 32'h0010);
    check("t1_mem_we",   mem_we_o[0],   0);
    check("t1_busy",     busy_o[0],     1);
    check("t1_if_ack_early", if_ack_o[0], 0);
    step();
    check("t1_if_ack",   if_ack_o[0],   1);
    check("t1_dm_ack",   dm_ack_o[0],   0);
    check("t1_if_rdata", if_rdata_o[0], 32'h0000_1234);
    check("t1_mem_en_off", mem_en_o[0], 0);
    if_req = 1'b0;
    step();
    check("t1_ack_pulse", if_ack_o[0], 0);
    check("t1_idle_busy", busy_o[0],   0);

    // ---- 2: DM write, MEM_LAT=1 ----
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 32'hBEEF_0001;
    mem_rdata = 32'hDEAD_DEAD;
    step();
    check("t2_mem_en",    mem_en_o[0],    1);
    check("t2_mem_we",    mem_we_o[0],    1);
    check("t2_mem_addr",  mem_addr_o[0],  32'h0020);
    check("t2_mem_wdata", mem_wdata_o[0], 32'hBEEF_0001);
    step();
    check("t2_dm_ack",    dm_ack_o[0],    1);
    check("t2_if_ack",    if_ack_o[0],    0);
    check("t2_dm_rdata",  dm_rdata_o[0],  0);
    check("t2_if_rdata",  if_rdata_o[0],  32'h0000_1234);
    check("t2_mem_we_off", mem_we_o[0],   0);
    dm_req = 1'b0; dm_we = 1'b0;
    step();

    // ---- 3a: tie with DM dropped after its ack ----
    do_reset();
    if_req = 1'b1; if_addr = 16'h0011;
    dm_req = 1'b1; dm_addr = 16'h0022; mem_rdata = 32'h3333_0003;
    step();
    check("t3_first_addr", mem_addr_o[0], 32'h0022);
    step();
    check("t3_dm_ack", dm_ack_o[0], 1);
    check("t3_if_ack_not_yet", if_ack_o[0], 0);
    dm_req = 1'b0;
    step();
    check("t3_gap_acks", {if_ack_o[0], dm_ack_o[0]}, 0);
    step();
    check("t3_second_addr", mem_addr_o[0], 32'h0011);
    step();
    check("t3_if_ack_3_after", if_ack_o[0], 1);
    check("t3_if_rdata", if_rdata_o[0], 32'h3333_0003);
    if_req = 1'b0;
    step();

    // ---- 3b: both held for four transactions ----
    do_reset();
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(6, got_dm, got_if);
`ifdef SISC_MEM_ARB_RR_EN
      exp_dm = (k % 2 == 0);
`else
      exp_dm = 1'b1;
`endif
      check($sformatf("t3_order_%0d", k), got_dm, exp_dm);
      check($sformatf("t3_excl_%0d", k), got_dm & got_if, 0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) step();

    // ---- 4: MEM_LAT=3 DM read ----
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0030; mem_rdata = 32'h1111_1111;
    step();
    check("t4_en_c1", mem_en_o[2], 1);
    check("t4_addr",  mem_addr_o[2], 32'h0030);
    mem_rdata = 32'h2222_2222;
    step();
    check("t4_en_c2", mem_en_o[2], 1);
    mem_rdata = 32'h3333_3333;
    step();
    check("t4_en_c3",  mem_en_o[2], 1);
    check("t4_no_ack", dm_ack_o[2], 0);
    step();
    check("t4_dm_ack",   dm_ack_o[2],   1);
    check("t4_dm_rdata", dm_rdata_o[2], 32'h3333_3333);
    check("t4_en_off",   mem_en_o[2],   0);
    dm_req = 1'b0;
    repeat (2) step();

    // ---- 5: reset during write ACCESS, MEM_LAT=1 ----
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0044; mem_rdata = 32'hCAFE_0005;
    step();
    step();
    check("t5_pre_read", dm_rdata_o[0], 32'hCAFE_0005);
    dm_req = 1'b0;
    step();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0040; dm_wdata = 32'h1234_5678;
    step();
    check("t5_in_write", mem_we_o[0], 1);
    #2 rst_f = 1'b0;
    #1;
    check("t5_rst_en",     mem_en_o[0],   0);
    check("t5_rst_we",     mem_we_o[0],   0);
    check("t5_rst_busy",   busy_o[0],     0);
    check("t5_rst_rdata",  dm_rdata_o[0], 0);
    dm_req = 1'b0; dm_we = 1'b0;
    @(posedge clk);
    #1 rst_f = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t5_no_ack_%0d", c), {if_ack_o[0], dm_ack_o[0]}, 0);
    end
    if_req = 1'b1; if_addr = 16'h0080; mem_rdata = 32'h0BAD_0080;
    step();
    check("t5_new_addr", mem_addr_o[0], 32'h0080);
    step();
    check("t5_new_ack",   if_ack_o[0],   1);
    check("t5_new_rdata", if_rdata_o[0], 32'h0BAD_0080);
    if_req = 1'b0;
    step();

    // ---- 6: IF raised during DM ACCESS, MEM_LAT=2 ----
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0050; mem_rdata = 32'h6666_0006;
    step();
    check("t6_dm_addr", mem_addr_o[1], 32'h0050);
    if_req = 1'b1; if_addr = 16'h0060; dm_addr = 16'h0099;
    step();
    check("t6_addr_held", mem_addr_o[1], 32'h0050);
    check("t6_en_held",   mem_en_o[1],   1);
    step();
    check("t6_dm_ack", dm_ack_o[1], 1);
    check("t6_if_ack", if_ack_o[1], 0);
    dm_req = 1'b0;
    step();
    check("t6_idle_en",   mem_en_o[1], 0);
    check("t6_idle_busy", busy_o[1],   0);
    step();
    check("t6_if_addr", mem_addr_o[1], 32'h0060);
    if_addr = 16'h0070;
    step();
    check("t6_if_addr_held", mem_addr_o[1], 32'h0060);
    step();
    check("t6_if_ack2",  if_ack_o[1],   1);
    check("t6_if_rdata", if_rdata_o[1], 32'h6666_0006);
    if_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
